// File: rtl/arb_pkg.sv
// ----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for decoder_rr_arbiter:
//   - state_e : arbiter FSM states (IDLE, GRANT)
//   - N_REQ   : number of requesters (16)
//   - IDX_W   : width of a requester index (4)
//   - rr_pick : round-robin selection. It rotates the request vector so that
//               the pointer lands at bit 0, priority-encodes the lowest set
//               bit, then rotates the result back into absolute index space.
// ----------------------------------------------------------------------------
package arb_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Returns the first set bit of req when searching ptr, ptr+1, ..., wrapping
  // modulo N_REQ. Returns ptr when req is zero; callers only use the result
  // when at least one request is set.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   off;
    dbl = {req, req};
    rot = dbl[ptr +: N_REQ];
    off = '0;
    // Scan high to low so the lowest set bit (closest to ptr) wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = IDX_W'(i);
      end
    end
    // Index arithmetic wraps naturally at IDX_W bits.
    return ptr + off;
  endfunction

endpackage

// File: rtl/decoder_rr_arbiter_dec.sv
// ----------------------------------------------------------------------------
// Decoder4to16
// Plain 4-to-16 one-hot decoder with enable; the shared resource driven by
// decoder_rr_arbiter.
// Ports:
//   in  [3:0]  : index to decode
//   en         : enable; all outputs are zero when low
//   out [15:0] : one-hot decode of in, or zero
// ----------------------------------------------------------------------------
module Decoder4to16 (
  input  logic [3:0]  in,
  input  logic        en,
  output logic [15:0] out
);

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_dec
      assign out[gi] = en && (in == 4'(gi));
    end
  endgenerate

endmodule

// File: rtl/decoder_rr_arbiter.sv
// ----------------------------------------------------------------------------
// decoder_rr_arbiter
// Round-robin arbiter sharing one 4-to-16 decoder among 16 requesters. A
// granted owner keeps the grant until it pulses done or drops its request;
// every release is followed by exactly one idle (dead) cycle.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When defined, a hold counter revokes a grant after MAX_HOLD cycles and
//   pulses timeout for one cycle. When undefined, no counter exists and
//   timeout is tied low.
//
// Parameters:
//   MAX_HOLD     : max cycles a grant may be held (timeout build), 2..65535
// Ports:
//   clk          : rising-edge clock
//   rst_n        : asynchronous active-low reset
//   req  [15:0]  : level-sensitive request lines, bit i = requester i
//   done         : one-cycle release pulse from the current owner
//   grant[15:0]  : one-hot grant, zero when idle
//   grant_idx[3:0]: current owner index, holds last value when idle
//   grant_valid  : high while a grant is active
//   timeout      : one-cycle pulse when the watchdog revokes a grant
// ----------------------------------------------------------------------------
module decoder_rr_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  input  logic              done,
  output logic [N_REQ-1:0]  grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              grant_valid,
  output logic              timeout
);

  if ((MAX_HOLD < 2) || (MAX_HOLD > 65535)) begin : g_bad_max_hold
    $error("decoder_rr_arbiter: MAX_HOLD must be in 2..65535");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             release_now;
  logic             revoke_now;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  // The counter holds the number of GRANT cycles already completed, so
  // reaching MAX_HOLD-1 means this is the last permitted cycle.
  assign revoke_now = (state_q == GRANT) && (cnt_q == CNT_W'(MAX_HOLD - 1));
  assign timeout    = timeout_q;
`else
  assign revoke_now = 1'b0;
  assign timeout    = 1'b0;
`endif

  assign release_now = (state_q == GRANT) && (done || !req[idx_q]);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        // done is deliberately ignored here.
        if (req != '0) begin
          idx_d   = rr_pick(req, ptr_q);
          state_d = GRANT;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
        if (release_now || revoke_now) begin
          state_d = IDLE;
          ptr_d   = idx_q + 1'b1;
`ifdef ARB_TIMEOUT_EN
          // A genuine release on the same edge takes precedence; the
          // watchdog only reports grants it actually had to take away.
          timeout_d = revoke_now && !release_now;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      ptr_q     <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign grant_valid = (state_q == GRANT);
  assign grant_idx   = idx_q;

  // The decoder is driven only from registers, so grant is glitch-free with
  // respect to req/done and cannot be nonzero unless grant_valid is high.
  Decoder4to16 u_dec (
    .in  (idx_q),
    .en  (grant_valid),
    .out (grant)
  );

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
module tb_decoder_rr_arbiter;

  localparam int MH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] req = 16'h0;
  logic        done = 1'b0;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        grant_valid;
  logic        timeout;

  int n_vec = 0;
  int n_mis = 0;

  decoder_rr_arbiter #(.MAX_HOLD(MH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // Behavioural model: who owns the resource, how long they have held it,
  // and where the next round-robin search starts.
  int m_ptr   = 0;
  int m_idx   = 0;
  bit m_valid = 0;
  bit m_to    = 0;
  int m_held  = 0;

  always @(posedge clk or negedge rst_n) begin
    int pick;
    bit rel, tmo;
    if (!rst_n) begin
      m_ptr <= 0; m_idx <= 0; m_valid <= 0; m_to <= 0; m_held <= 0;
    end else if (!m_valid) begin
      pick = -1;
      for (int k = 0; k < 16; k++) begin
        if (pick < 0 && req[(m_ptr + k) % 16]) pick = (m_ptr + k) % 16;
      end
      m_to <= 0;
      if (pick >= 0) begin
        m_idx <= pick; m_valid <= 1; m_held <= 1;
      end
    end else begin
      rel = done || !req[m_idx];
      tmo = TO_EN && (m_held >= MH);
      if (rel || tmo) begin
        m_valid <= 0;
        m_to    <= tmo && !rel;
        m_ptr   <= (m_idx + 1) % 16;
      end else begin
        m_to   <= 0;
        m_held <= m_held + 1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_grant", 32'(grant), m_valid ? (32'd1 << m_idx) : 32'd0);
      chk("model_idx", 32'(grant_idx), 32'(m_idx));
      chk("model_valid", 32'(grant_valid), 32'(m_valid));
      chk("model_timeout", 32'(timeout), 32'(m_to));
    end
  end

  // Asynchronous reset pulse mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_grant", 32'(grant), 32'h0);
    chk("async_valid", 32'(grant_valid), 32'h0);
    chk("async_idx", 32'(grant_idx), 32'h0);
    chk("async_timeout", 32'(timeout), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("dead_cycle", 32'(grant_valid), 32'h0);
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    // Reset held with every request set.
    req = 16'hFFFF;
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_valid", 32'(grant_valid), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_grant", 32'(grant), 32'h0001);
    chk("first_idx", 32'(grant_idx), 32'h0);
    for (int i = 1; i <= 16; i++) begin
      pulse_done();
      chk("rr_idx", 32'(grant_idx), 32'(i % 16));
      chk("rr_grant", 32'(grant), 32'd1 << (i % 16));
    end

    // Wrap between the two ends of the request vector.
    req = 16'h8001;
    do_reset();
    @(negedge clk);
    chk("wrap_idx0", 32'(grant_idx), 32'h0);
    pulse_done();
    chk("wrap_idx15", 32'(grant_idx), 32'hF);
    chk("wrap_grant15", 32'(grant), 32'h8000);
    pulse_done();
    chk("wrap_back0", 32'(grant_idx), 32'h0);

    // Owner drops its request without done.
    req = 16'h0020;
    do_reset();
    @(negedge clk);
    chk("drop_owner", 32'(grant_idx), 32'h5);
    req = 16'h0008;
    @(negedge clk);
    chk("drop_valid", 32'(grant_valid), 32'h0);
    @(negedge clk);
    chk("drop_next_idx", 32'(grant_idx), 32'h3);
    chk("drop_next_valid", 32'(grant_valid), 32'h1);

`ifdef ARB_TIMEOUT_EN
    // Watchdog revoke, then done coinciding with the last permitted cycle.
    req = 16'h0180;
    do_reset();
    @(negedge clk);
    cyc = 0;
    while (grant_valid && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    chk("to_hold_cycles", 32'(cyc), 32'(MH));
    chk("to_pulse", 32'(timeout), 32'h1);
    @(negedge clk);
    chk("to_next_idx", 32'(grant_idx), 32'h8);
    chk("to_pulse_gone", 32'(timeout), 32'h0);
    repeat (MH - 1) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("to_done_valid", 32'(grant_valid), 32'h0);
    chk("to_done_timeout", 32'(timeout), 32'h0);
`else
    cyc = 0;
`endif

    // Randomized traffic; requests change in bursts so grants can persist.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 3) == 0) req = 16'h0;
        else req = 16'($urandom) & 16'($urandom);
      end
      done = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 499) == 0) begin
        done = 1'b0;
        do_reset();
      end
    end
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
